// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver. Deserialises an idle-high, LSB-first serial
//               line into DATA_BITS-wide words. An optional even-parity bit
//               is enabled with the UART_RX_PARITY_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int BAUD      = 9600,
    parameter int SYS_CLK   = 12000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 rx_wire,
    output logic [DATA_BITS-1:0] rx_output,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 busy,
    output logic                 parity_error
);

    localparam int CLKS_PER_BIT = SYS_CLK / BAUD;
    localparam int c_CNT_W      = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [c_CNT_W-1:0] c_BIT_END  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_END = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd3;
`endif

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_rx_prev;
    logic                 w_rx_s;

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;

    logic [c_CNT_W-1:0]   r_clk_cnt;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_output;
    logic                 r_data_valid;
    logic                 r_frame_error;

    logic                 w_start_edge;
    logic                 w_cnt_end;
    logic                 w_last_bit;
    logic                 w_stop_sample;
    logic                 w_accept;
    logic                 w_framing;
    logic                 w_busy;

`ifdef UART_RX_PARITY_EN
    logic                 r_parity_bit;
    logic                 r_parity_error;
    logic                 w_parity_bad;
    logic                 w_parity_fail;
`endif

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx_wire;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_rx_s       = r_sync2;
    assign w_start_edge = enable & r_rx_prev & ~w_rx_s;
    // START waits half a bit so every later sample lands mid-bit.
    assign w_cnt_end    = (r_state == c_START) ? (r_clk_cnt == c_HALF_END)
                                               : (r_clk_cnt == c_BIT_END);
    assign w_last_bit   = (r_bit_idx == c_LAST_IDX);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_start_edge) begin
                    w_next_state = c_START;
                end
            end
            c_START: begin
                if (w_cnt_end) begin
                    w_next_state = w_rx_s ? c_IDLE : c_DATA;
                end
            end
            c_DATA: begin
                if (w_cnt_end && w_last_bit) begin
`ifdef UART_RX_PARITY_EN
                    w_next_state = c_PARITY;
`else
                    w_next_state = c_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            c_PARITY: begin
                if (w_cnt_end) begin
                    w_next_state = c_STOP;
                end
            end
`endif
            c_STOP: begin
                if (w_cnt_end) begin
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
        if (!enable) begin
            w_next_state = c_IDLE;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_stop_sample = enable & (r_state == c_STOP) & w_cnt_end;
        w_framing     = w_stop_sample & ~w_rx_s;
`ifdef UART_RX_PARITY_EN
        w_parity_bad  = ^{r_shift, r_parity_bit};
        w_accept      = w_stop_sample & w_rx_s & ~w_parity_bad;
        w_parity_fail = w_stop_sample & w_rx_s & w_parity_bad;
        // Busy stays up through the result pulse so consumers see one window.
        w_busy        = (r_state != c_IDLE) | r_data_valid | r_frame_error
                        | r_parity_error;
`else
        w_accept      = w_stop_sample & w_rx_s;
        w_busy        = (r_state != c_IDLE) | r_data_valid | r_frame_error;
`endif
    end

    // ------------------------------------------------------------------------
    // Datapath: counters, shift register and registered result pulses
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_cnt     <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_rx_output   <= '0;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_data_valid  <= w_accept;
            r_frame_error <= w_framing;

            if (w_accept) begin
                r_rx_output <= r_shift;
            end

            if ((r_state == c_IDLE) || w_cnt_end || !enable) begin
                r_clk_cnt <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end

            if (r_state == c_IDLE) begin
                r_bit_idx <= '0;
            end else if ((r_state == c_DATA) && w_cnt_end) begin
                r_shift[r_bit_idx] <= w_rx_s;
                r_bit_idx          <= r_bit_idx + 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity_bit   <= 1'b0;
            r_parity_error <= 1'b0;
        end else begin
            r_parity_error <= w_parity_fail;
            if ((r_state == c_PARITY) && w_cnt_end) begin
                r_parity_bit <= w_rx_s;
            end
        end
    end

    assign parity_error = r_parity_error;
`else
    assign parity_error = 1'b0;
`endif

    assign rx_output   = r_rx_output;
    assign data_valid  = r_data_valid;
    assign frame_error = r_frame_error;
    assign busy        = w_busy;

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the `uart` transmitter.
- Deserialises an asynchronous 8N1-style line into parallel words.
- Shares the transmitter's DATA_BITS/BAUD/SYS_CLK parameters so a tx/rx pair configured identically interoperates.
- Sits between an external RX pin and the consuming logic; one clean frame yields one data_valid pulse.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first
- BAUD, 9600, line rate in bit/s
- SYS_CLK, 12000000, clk frequency in Hz
- CLKS_PER_BIT (localparam) = SYS_CLK/BAUD, integer division (1250 at defaults)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- enable  input  1  receiver enable; 0 holds the FSM in IDLE
- rx_wire  input  1  serial line, idle high, asynchronous to clk
- rx_output  output  DATA_BITS  last correctly framed word
- data_valid  output  1  one-cycle pulse when rx_output updates
- frame_error  output  1  one-cycle pulse when the stop bit is sampled low
- busy  output  1  high while the FSM is in any state other than IDLE
- parity_error  output  1  see Optional Feature; tied 0 without the macro

Behaviour:
- Reset values (asynchronous on rst): all outputs 0; rx_output = 0; both synchroniser flops = 1; FSM = IDLE; bit counter and clock counter = 0.
- Input synchroniser: rx_wire passes through 2 flops, giving rx_s. An edge register holds rx_s delayed by 1 cycle.
- Clock counter width: $clog2(CLKS_PER_BIT).
- State IDLE:
  - Start is detected on rx_s falling edge (previous sample 1, current sample 0) while enable=1, then go to START.
  - A line held low without a preceding high does not start a frame.
- State START:
  - Count CLKS_PER_BIT/2 cycles, then resample rx_s.
  - rx_s = 0: clear the clock counter and go to DATA.
  - rx_s = 1: treat as a glitch and return to IDLE with no pulse.
- State DATA:
  - Every CLKS_PER_BIT cycles, sample rx_s into shift register bit[i], for i = 0..DATA_BITS-1 (LSB first).
  - After the last bit, go to PARITY if the macro is defined, otherwise go to STOP.
- State STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - rx_s = 1: load rx_output from the shift register and pulse data_valid for exactly 1 cycle, in the cycle after the stop sample.
  - rx_s = 0: pulse frame_error for 1 cycle; rx_output keeps its previous value.
  - In both cases return to IDLE. A new start edge is accepted from the next cycle.
- Latency: data_valid occurs about (DATA_BITS + 1.5) × CLKS_PER_BIT + 3 cycles after the rx_wire falling edge (2 synchroniser cycles + 1 register cycle).
- Data is accepted only mid-bit; a frame whose start bit is shorter than half a bit is ignored.
- enable deasserted mid-frame: abort to IDLE on the next cycle; no data_valid or frame_error; rx_output unchanged.
- rst mid-frame: immediate abort; all state returns to reset values.
- data_valid and frame_error are never high in the same cycle.
- busy is high from the cycle START is entered until the cycle IDLE is re-entered.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and samples one even-parity bit after CLKS_PER_BIT cycles.
  - At the stop bit, if XOR of data and parity bit = 1: pulse parity_error instead of data_valid; rx_output is not updated.
  - frame_error takes precedence over parity_error when both apply.
- Undefined: no parity state; parity_error is constant 0; frame length = DATA_BITS + 2 bits.

Test Plan:
1. Idle: rx_wire = 1 for 20000 cycles -> data_valid, frame_error and busy stay 0; rx_output = 0x00.
2. Send 0xA5 (bits 0, 1,0,1,0,0,1,0,1, 1; 1250 clk/bit) -> exactly one data_valid pulse; rx_output = 0xA5; busy falls the cycle after the pulse.
3. Back-to-back 0x3C then 0xC3, with no idle gap after the stop bit -> two data_valid pulses about 12500 cycles apart; rx_output = 0x3C, then 0xC3.
4. Framing error: send 0x5A with stop bit = 0, then idle -> one frame_error pulse; no data_valid; rx_output retains the prior value (0xC3).
5. Glitch: drive rx_wire low for 400 cycles (< 625), then high -> FSM returns to IDLE; no pulses. A following 0x81 frame is then received correctly.
6. Abort: assert rst, or deassert enable, 5 bits into a 0xFF frame -> busy = 0 within 1 cycle; no pulses. The next 0x42 frame is received correctly. With UART_RX_PARITY_EN defined, 0x42 with parity bit 1 -> parity_error pulse and no data_valid.
